// File: rtl/pixart_pkg.sv
// pixart_pkg: shared constants, state encoding and init table for the Pixart camera sequencer
package pixart_pkg;
    localparam logic [3:0] S_PWRUP      = 4'd0;
    localparam logic [3:0] S_WAIT_START = 4'd1;
    localparam logic [3:0] S_INIT_REQ   = 4'd2;
    localparam logic [3:0] S_INIT_WAIT  = 4'd3;
    localparam logic [3:0] S_INIT_GAP   = 4'd4;
    localparam logic [3:0] S_POLL_REQ   = 4'd5;
    localparam logic [3:0] S_POLL_WAIT  = 4'd6;
    localparam logic [3:0] S_POLL_GAP   = 4'd7;
    localparam logic [3:0] S_ERROR      = 4'd8;
    localparam logic [7:0] POLL_REG     = 8'h36;
    localparam logic [4:0] POLL_LEN     = 5'd4;
    localparam logic [9:0] NO_BLOB      = 10'd1023;
    localparam int         INIT_LEN     = 6;
    typedef struct packed {
        logic [7:0] rg;
        logic [7:0] data;
    } init_t;
    // entry 0 is the rightmost word
    localparam init_t [INIT_LEN-1:0] INIT_TABLE = {
        16'h3333, 16'h1A40, 16'h08C0, 16'h0690, 16'h3008, 16'h3001
    };
    function automatic init_t init_entry(input logic [2:0] idx);
        return INIT_TABLE[idx];
    endfunction
endpackage

// File: rtl/pixart_blob_decode.sv
// pixart_blob_decode: captures the four poll bytes and decodes blob 1 position
module pixart_blob_decode
    import pixart_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [4:0] o_count,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_no_blob
);
    logic [4:0] r_cnt;
    logic [7:0] r_xlo, r_ylo, r_s;
    logic [7:0] w_xlo, w_ylo, w_s;
    logic       w_take;
    // decode from next-state bytes so a byte arriving with txn_done is already included
    always_comb begin
        w_take    = i_en && i_rx_valid && r_cnt != POLL_LEN;
        o_count   = r_cnt + {4'd0, w_take};
        w_xlo     = (w_take && r_cnt == 5'd1) ? i_rx_data : r_xlo;
        w_ylo     = (w_take && r_cnt == 5'd2) ? i_rx_data : r_ylo;
        w_s       = (w_take && r_cnt == 5'd3) ? i_rx_data : r_s;
        o_x       = {w_s[5:4], w_xlo};
        o_y       = {w_s[7:6], w_ylo};
        o_no_blob = o_x == NO_BLOB && o_y == NO_BLOB;
    end
    // byte counter restarts whenever no poll read is in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_xlo <= '0;
            r_ylo <= '0;
            r_s   <= '0;
        end else begin
            r_cnt <= i_en ? o_count : '0;
            r_xlo <= w_xlo;
            r_ylo <= w_ylo;
            r_s   <= w_s;
        end
    end
endmodule

// File: rtl/pixart_seq.sv
// pixart_seq: init-then-poll sequencer for the Pixart IR camera over a transaction-level I2C master
module pixart_seq
    import pixart_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h58,
    parameter int          POWERUP_CYCLES = 1000,
    parameter int          GAP_CYCLES     = 100,
    parameter int          POLL_CYCLES    = 2000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       txn_valid,
    input  logic       txn_ready,
    output logic       txn_rw,
    output logic [6:0] txn_dev,
    output logic [7:0] txn_reg,
    output logic [7:0] txn_wdata,
    output logic [4:0] txn_rlen,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       txn_done,
    input  logic       txn_nack,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       xy_valid,
    output logic       blob_seen,
    output logic       init_done,
    output logic       error
);
    localparam logic [3:0] L_MAX_RETRY = 4'(MAX_RETRY);
    localparam logic [2:0] L_LAST      = 3'(INIT_LEN - 1);
    logic [3:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [3:0]  r_fail;
    logic        r_long;
    logic [9:0]  r_x, r_y;
    logic        r_xy_valid, r_blob, r_init_done;
    logic [15:0] w_lim;
    logic        w_cnt_end, w_init_req, w_poll_req, w_in_init, w_ok;
    logic [3:0]  w_fail;
    logic [4:0]  w_nbytes;
    logic [9:0]  w_dx, w_dy;
    logic        w_no_blob;
    init_t       w_entry;
    pixart_blob_decode u_decode (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (r_state == S_POLL_WAIT),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_count    (w_nbytes),
        .o_x        (w_dx),
        .o_y        (w_dy),
        .o_no_blob  (w_no_blob)
    );
    // request fields are pure functions of state so they stay stable until accepted
    always_comb begin
        w_entry    = init_entry(r_idx);
        w_init_req = r_state == S_INIT_REQ;
        w_poll_req = r_state == S_POLL_REQ;
        w_in_init  = r_state == S_INIT_WAIT;
        w_ok       = !txn_nack && (w_in_init || w_nbytes == POLL_LEN);
        w_fail     = r_fail + 4'd1;
        w_lim      = (r_state == S_PWRUP) ? 16'(POWERUP_CYCLES)
                   : (r_state == S_POLL_GAP && r_long) ? 16'(POLL_CYCLES) : 16'(GAP_CYCLES);
        w_cnt_end  = r_cnt == w_lim - 16'd1;
    end
    assign txn_valid = w_init_req || w_poll_req;
    assign txn_rw    = w_poll_req;
    assign txn_dev   = DEV_ADDR;
    assign txn_reg   = w_init_req ? w_entry.rg : w_poll_req ? POLL_REG : 8'h00;
    assign txn_wdata = w_init_req ? w_entry.data : 8'h00;
    assign txn_rlen  = w_poll_req ? POLL_LEN : 5'd0;
    assign x         = r_x;
    assign y         = r_y;
    assign xy_valid  = r_xy_valid;
    assign blob_seen = r_blob;
    assign init_done = r_init_done;
    assign error     = r_state == S_ERROR;
    // sequencer: power-up wait, init table, periodic poll, failure retry and terminal error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_fail      <= '0;
            r_long      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_xy_valid  <= 1'b0;
            r_blob      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_xy_valid <= 1'b0;
            case (r_state)
                S_PWRUP, S_INIT_GAP, S_POLL_GAP: begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + 16'd1;
                    if (w_cnt_end)
                        r_state <= (r_state == S_PWRUP) ? S_WAIT_START
                                 : (r_state == S_POLL_GAP || r_init_done) ? S_POLL_REQ : S_INIT_REQ;
                end
                S_WAIT_START: if (start) r_state <= S_INIT_REQ;
                S_INIT_REQ:   if (txn_ready) r_state <= S_INIT_WAIT;
                S_POLL_REQ:   if (txn_ready) r_state <= S_POLL_WAIT;
                S_INIT_WAIT, S_POLL_WAIT: if (txn_done) begin
                    r_fail  <= w_ok ? '0 : w_fail;
                    r_long  <= w_ok;
                    r_state <= (!w_ok && w_fail == L_MAX_RETRY) ? S_ERROR
                             : w_in_init ? S_INIT_GAP : S_POLL_GAP;
                    if (w_in_init) begin
                        r_idx       <= !w_ok ? 3'd0 : (r_idx == L_LAST) ? r_idx : r_idx + 3'd1;
                        r_init_done <= r_init_done || (w_ok && r_idx == L_LAST);
                    end else if (w_ok) begin
                        r_blob <= !w_no_blob;
                        if (!w_no_blob) begin
                            r_x        <= w_dx;
                            r_y        <= w_dy;
                            r_xy_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pixart_seq.sv
// tb_pixart_seq: directed + randomized bench with a transaction-level master and behavioural model
module tb_pixart_seq;
    localparam int PWR  = 1000;
    localparam int GAP  = 100;
    localparam int POLL = 2000;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic       txn_ready = 1'b0, rx_valid = 1'b0, txn_done = 1'b0, txn_nack = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       txn_valid, txn_rw, xy_valid, blob_seen, init_done, error;
    logic [6:0] txn_dev;
    logic [7:0] txn_reg, txn_wdata;
    logic [4:0] txn_rlen;
    logic [9:0] x, y;

    int errors = 0, checks = 0;
    int m_next = 0, m_pulse = 0, m_fail = 0;
    logic m_init = 1'b0, m_blob = 1'b0;
    logic [9:0] m_x = '0, m_y = '0;
    logic [7:0] init_reg[6] = '{8'h30, 8'h30, 8'h06, 8'h08, 8'h1A, 8'h33};
    logic [7:0] init_dat[6] = '{8'h01, 8'h08, 8'h90, 8'hC0, 8'h40, 8'h33};
    logic [7:0] zb[6] = '{default: 8'h00};
    logic [7:0] b[6];

    always #5 clk = ~clk;

    pixart_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .txn_valid (txn_valid),
        .txn_ready (txn_ready),
        .txn_rw    (txn_rw),
        .txn_dev   (txn_dev),
        .txn_reg   (txn_reg),
        .txn_wdata (txn_wdata),
        .txn_rlen  (txn_rlen),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .txn_done  (txn_done),
        .txn_nack  (txn_nack),
        .x         (x),
        .y         (y),
        .xy_valid  (xy_valid),
        .blob_seen (blob_seen),
        .init_done (init_done),
        .error     (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " valid"}, txn_valid, 0);
        chk({tag, " rw"}, txn_rw, 0);
        chk({tag, " dev"}, txn_dev, 7'h58);
        chk({tag, " reg"}, txn_reg, 0);
        chk({tag, " wdata"}, txn_wdata, 0);
        chk({tag, " rlen"}, txn_rlen, 0);
        chk({tag, " x"}, x, 0);
        chk({tag, " y"}, y, 0);
        chk({tag, " xy_valid"}, xy_valid, 0);
        chk({tag, " blob"}, blob_seen, 0);
        chk({tag, " init_done"}, init_done, 0);
        chk({tag, " error"}, error, 0);
    endtask

    // waits for a request; checks the idle length and number of xy_valid pulses seen meanwhile
    task automatic wait_valid(input string tag, input int exp_n, input int exp_pulses);
        int n = 0, p = 0;
        while (!txn_valid && n < 25000) begin
            if (xy_valid) p++;
            @(negedge clk);
            n++;
        end
        chk({tag, " wait"}, n, exp_n);
        chk({tag, " xy pulses"}, p, exp_pulses);
    endtask

    task automatic accept(input string tag, input logic rw, input logic [7:0] rg, input logic [7:0] wd,
                          input logic [4:0] rl, input int stall);
        int bad = 0;
        chk({tag, " rw"}, txn_rw, rw);
        chk({tag, " reg"}, txn_reg, rg);
        chk({tag, " wdata"}, txn_wdata, wd);
        chk({tag, " rlen"}, txn_rlen, rl);
        chk({tag, " dev"}, txn_dev, 7'h58);
        repeat (stall) begin
            @(negedge clk);
            if (!txn_valid || txn_rw !== rw || txn_reg !== rg || txn_wdata !== wd || txn_rlen !== rl
                || txn_dev !== 7'h58) bad++;
        end
        if (stall > 0) chk({tag, " stall stable"}, bad, 0);
        txn_ready = 1'b1;
        @(negedge clk);
        txn_ready = 1'b0;
        chk({tag, " valid drops"}, txn_valid, 0);
    endtask

    task automatic complete(input logic nack, input int nb, input logic [7:0] bytes[6], input bit same);
        repeat ($urandom_range(3, 0)) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            txn_done = same && i == nb - 1;
            txn_nack = nack && txn_done;
            @(negedge clk);
        end
        if (!(same && nb > 0)) begin
            rx_valid = 1'b0;
            txn_done = 1'b1;
            txn_nack = nack;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        txn_done = 1'b0;
        txn_nack = 1'b0;
    endtask

    task automatic do_init(input int idx, input logic nack, input int stall);
        string tag = $sformatf("init%0d", idx);
        wait_valid(tag, m_next, m_pulse);
        accept(tag, 1'b0, init_reg[idx], init_dat[idx], 5'd0, stall);
        complete(nack, 0, zb, 1'b0);
        m_fail  = nack ? m_fail + 1 : 0;
        m_init  = m_init || (!nack && idx == 5);
        m_next  = GAP;
        m_pulse = 0;
        chk({tag, " init_done"}, init_done, m_init);
        chk({tag, " error"}, error, m_fail >= 3);
    endtask

    task automatic do_poll(input string tag, input logic nack, input int nb, input logic [7:0] bytes[6],
                           input bit same);
        int px, py;
        wait_valid(tag, m_next, m_pulse);
        accept(tag, 1'b1, 8'h36, 8'h00, 5'd4, 0);
        complete(nack, nb, bytes, same);
        m_pulse = 0;
        if (!nack && nb >= 4) begin
            m_fail = 0;
            m_next = POLL;
            px = (bytes[3] / 16 % 4) * 256 + bytes[1];
            py = (bytes[3] / 64) * 256 + bytes[2];
            if (px == 1023 && py == 1023) m_blob = 1'b0;
            else begin
                m_blob  = 1'b1;
                m_x     = 10'(px);
                m_y     = 10'(py);
                m_pulse = 1;
            end
        end else begin
            m_fail++;
            m_next = GAP;
        end
        chk({tag, " x"}, x, m_x);
        chk({tag, " y"}, y, m_y);
        chk({tag, " blob"}, blob_seen, m_blob);
        chk({tag, " xy_valid"}, xy_valid, m_pulse);
        chk({tag, " error"}, error, m_fail >= 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, xyb;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;
        vc = 0;
        repeat (1100) begin
            @(negedge clk);
            if (txn_valid) vc++;
        end
        chk("no start valid", vc, 0);
        start   = 1'b1;
        m_next  = 1;
        m_pulse = 0;
        do_init(0, 1'b0, 0);
        do_init(1, 1'b0, 0);
        do_init(2, 1'b0, 50);
        do_init(3, 1'b1, 0);
        for (int i = 0; i < 6; i++) do_init(i, 1'b0, 0);
        start = 1'b0;
        b = '{8'h00, 8'h34, 8'h12, 8'h50, 8'h00, 8'h00};
        do_poll("blob", 1'b0, 4, b, 1'b0);
        chk("blob x const", x, 10'h134);
        chk("blob y const", y, 10'h112);
        b = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        do_poll("noblob", 1'b0, 4, b, 1'b1);
        chk("noblob x held", x, 10'h134);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
            if (k % 4 == 3) begin
                b[1] = 8'hFF;
                b[2] = 8'hFF;
                b[3] = 8'hFF;
            end
            do_poll($sformatf("rand%0d", k), 1'b0, 4 + k % 2, b, 1'($urandom_range(1, 0)));
        end
        do_poll("nack1", 1'b1, 0, b, 1'b0);
        do_poll("short", 1'b0, 3, b, 1'b1);
        b = '{8'h00, 8'hA5, 8'h5A, 8'h90, 8'h00, 8'h00};
        do_poll("recover", 1'b0, 4, b, 1'b0);
        do_poll("fail1", 1'b1, 0, b, 1'b0);
        do_poll("fail2", 1'b1, 2, b, 1'b0);
        do_poll("fail3", 1'b1, 0, b, 1'b0);
        chk("error set", error, 1);
        vc  = 0;
        xyb = 0;
        for (int i = 0; i < 10 * POLL + 100; i++) begin
            txn_done = (i == 500);
            @(negedge clk);
            if (txn_valid) vc++;
            if (x !== m_x || y !== m_y || xy_valid) xyb++;
        end
        txn_done = 1'b0;
        chk("error no valid", vc, 0);
        chk("error xy held", xyb, 0);
        chk("error sticky", error, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("rst2");
        reset_n = 1'b1;
        start   = 1'b1;
        m_next  = PWR + 1;
        m_pulse = 0;
        m_fail  = 0;
        m_init  = 1'b0;
        m_blob  = 1'b0;
        m_x     = '0;
        m_y     = '0;
        for (int i = 0; i < 6; i++) do_init(i, 1'b0, 0);
        b = '{8'h00, 8'h00, 8'($urandom), 8'($urandom), 8'h00, 8'h00};
        do_poll("post", 1'b0, 4, b, 1'b0);
        wait_valid("mid", m_next, m_pulse);
        accept("mid", 1'b1, 8'h36, 8'h00, 5'd4, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (2) @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        txn_ready = 1'b0;
        @(negedge clk);
        check_reset("rst3");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
